// File: rtl/adder_seq_ctrl_pkg.sv
// Shared types and default sizing for the sequential chunk-adder controller.
package adder_ctrl_pkg;

    localparam int DEF_CHUNK_BITS = 4;
    localparam int DEF_NUM_CHUNKS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Request/response bundle between a requesting datapath and the controller.
interface adder_seq_ctrl_if
    import adder_ctrl_pkg::*;
#(
    parameter int CHUNK_BITS = DEF_CHUNK_BITS,
    parameter int NUM_CHUNKS = DEF_NUM_CHUNKS
);
    localparam int TOTAL_BITS = CHUNK_BITS * NUM_CHUNKS;

    logic                  start;
    logic [TOTAL_BITS-1:0] a;
    logic [TOTAL_BITS-1:0] b;
    logic                  carry_in;
    logic                  busy;
    logic                  done;
    logic [TOTAL_BITS-1:0] sum;
    logic                  overflow;

    modport master (
        output start, a, b, carry_in,
        input  busy, done, sum, overflow
    );

    modport slave (
        input  start, a, b, carry_in,
        output busy, done, sum, overflow
    );

endinterface

// File: rtl/adder_seq_ctrl_nbit.sv
// Purely combinational ripple-carry chunk adder shared by the controller.
module adder_nbit #(
    parameter int BIT_WIDTH = 4
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    logic c;

    // Ripple the carry from bit 0 upward, one full adder per bit.
    always_comb begin
        sum = '0;
        c   = carry_in;
        for (int i = 0; i < BIT_WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        overflow = c;
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide unsigned adder built from one narrow chunk adder, one chunk per cycle,
// LSB chunk first, with a start/busy/done handshake and registered results.
module adder_seq_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int CHUNK_BITS = DEF_CHUNK_BITS,
    parameter int NUM_CHUNKS = DEF_NUM_CHUNKS
) (
    input  logic             clk,
    input  logic             rst,
    adder_seq_ctrl_if.slave  bus
);

    localparam int TOTAL_BITS = CHUNK_BITS * NUM_CHUNKS;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    state_t                state;
    logic [TOTAL_BITS-1:0] a_sh;
    logic [TOTAL_BITS-1:0] b_sh;
    logic [TOTAL_BITS-1:0] psum;
    logic                  carry;
    logic [CNT_W-1:0]      cnt;

    logic                  busy_q;
    logic                  done_q;
    logic [TOTAL_BITS-1:0] sum_q;
    logic                  ovf_q;

    logic [CHUNK_BITS-1:0] ch_sum;
    logic                  ch_co;
    logic [TOTAL_BITS-1:0] nxt_psum;

    adder_nbit #(
        .BIT_WIDTH (CHUNK_BITS)
    ) u_chunk (
        .a        (a_sh[CHUNK_BITS-1:0]),
        .b        (b_sh[CHUNK_BITS-1:0]),
        .carry_in (carry),
        .sum      (ch_sum),
        .overflow (ch_co)
    );

    // New chunk enters at the top; after NUM_CHUNKS shifts chunk 0 sits at the bottom.
    assign nxt_psum = {ch_sum, psum[TOTAL_BITS-1:CHUNK_BITS]};

    // Controller FSM with operand/partial-sum datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            psum   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        carry  <= bus.carry_in;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    psum  <= nxt_psum;
                    carry <= ch_co;
                    a_sh  <= a_sh >> CHUNK_BITS;
                    b_sh  <= b_sh >> CHUNK_BITS;
                    if (cnt == LAST_CHUNK) begin
                        // Commit only the complete result; outputs never see partials.
                        cnt    <= '0;
                        sum_q  <= nxt_psum;
                        ovf_q  <= ch_co;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl: directed cases plus random operands
// against a plain-arithmetic reference model.
module tb_adder_seq_ctrl;

    localparam int CB = 4;
    localparam int NC = 4;
    localparam int W  = CB * NC;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    logic [W-1:0] exp_sum;
    logic         exp_ovf;

    adder_seq_ctrl_if #(.CHUNK_BITS(CB), .NUM_CHUNKS(NC)) bus ();

    adder_seq_ctrl #(.CHUNK_BITS(CB), .NUM_CHUNKS(NC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // mode: 0 plain, 1 change a to 00FF during ADD, 2 random operand churn during ADD,
    //       3 assert start during the DONE cycle
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int mode);
        logic [W:0] model;
        int done_k;
        int busy_cnt;
        model = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = cin;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (mode == 1) bus.a = 16'h00FF;
        if (mode == 2) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            bus.carry_in = 1'($urandom);
        end
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        check("done_after_accept", {31'd0, bus.done}, 32'd0);
        busy_cnt = 1;
        done_k   = -1;
        for (int k = 1; k <= NC + 3; k++) begin
            @(posedge clk);
            #1;
            if (mode == 2) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
            end
            if (bus.done) begin
                done_k = k;
                break;
            end
            check("sum_hold", {16'd0, bus.sum}, {16'd0, exp_sum});
            check("ovf_hold", {31'd0, bus.overflow}, {31'd0, exp_ovf});
            if (bus.busy) busy_cnt++;
        end
        if (done_k < 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            exp_sum = model[W-1:0];
            exp_ovf = model[W];
            check("done_latency", done_k, NC);
            check("busy_cycles", busy_cnt, NC);
            check("busy_in_done", {31'd0, bus.busy}, 32'd0);
            check("sum", {16'd0, bus.sum}, {16'd0, exp_sum});
            check("overflow", {31'd0, bus.overflow}, {31'd0, exp_ovf});
            if (mode == 3) bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            check("done_one_cycle", {31'd0, bus.done}, 32'd0);
            check("idle_after_done", {31'd0, bus.busy}, 32'd0);
            if (mode == 3) begin
                @(posedge clk);
                #1;
                check("start_in_done_ignored", {31'd0, bus.busy}, 32'd0);
            end
        end
    endtask

    initial begin
        int pulses[$];
        n_checks     = 0;
        n_fail       = 0;
        exp_sum      = '0;
        exp_ovf      = 1'b0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.carry_in = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum", {16'd0, bus.sum}, 32'd0);
        check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed cases
        run_op(16'h1234, 16'h4321, 1'b0, 0);
        check("basic_sum", {16'd0, bus.sum}, 32'h5555);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0);
        check("ripple_sum", {15'd0, bus.overflow, bus.sum}, 32'h10000);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
        check("max_sum", {15'd0, bus.overflow, bus.sum}, 32'h1FFFF);
        run_op(16'h8000, 16'h8000, 1'b0, 0);
        check("msb_sum", {15'd0, bus.overflow, bus.sum}, 32'h10000);
        run_op(16'h0001, 16'h0001, 1'b0, 1);
        check("operand_change_sum", {16'd0, bus.sum}, 32'h0002);
        run_op(16'h0F0F, 16'h00F1, 1'b1, 3);

        // start held high: one accept every NC+2 cycles
        @(negedge clk);
        bus.a        = 16'h0001;
        bus.b        = 16'h0001;
        bus.carry_in = 1'b0;
        bus.start    = 1'b1;
        for (int k = 0; k < 40 && pulses.size() < 4; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                pulses.push_back(k);
                check("held_start_sum", {15'd0, bus.overflow, bus.sum}, 32'h0002);
            end
        end
        bus.start = 1'b0;
        check("held_start_pulses", pulses.size(), 4);
        for (int i = 1; i < pulses.size(); i++)
            check("held_start_period", pulses[i] - pulses[i-1], NC + 2);
        exp_sum = 16'h0002;
        exp_ovf = 1'b0;
        repeat (NC + 3) @(posedge clk);

        // asynchronous reset in the second ADD cycle
        @(negedge clk);
        bus.a        = 16'hABCD;
        bus.b        = 16'h1111;
        bus.carry_in = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_sum", {16'd0, bus.sum}, 32'd0);
        check("midrst_ovf", {31'd0, bus.overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_sum = '0;
        exp_ovf = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < NC + 3; k++) begin
                @(posedge clk);
                #1;
                if (bus.done || bus.busy) seen++;
            end
            check("midrst_no_done", seen, 0);
        end
        run_op(16'hABCD, 16'h1111, 1'b0, 0);
        check("after_rst_sum", {15'd0, bus.overflow, bus.sum}, 32'h0BCDE);

        // randomised operands, idle gaps and operand churn
        for (int n = 0; n < 2000; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 2 : 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
